// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: default widths,
// memory depth, PC register latency, state encoding and the reset PC.
package fetch_pkg;

    localparam int FETCH_PC_BITS        = 8;
    localparam int FETCH_INST_BITS      = 8;
    localparam int FETCH_INST_MEM_DEPTH = 24;
    localparam int FETCH_PC_LATENCY     = 2;

    localparam logic [FETCH_PC_BITS-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        S_SETTLE  = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

endpackage : fetch_pkg

// File: rtl/fetch_next_pc.sv
// Next-PC computation: sequential increment or branch target, folded back to
// zero when it leaves the instruction memory. An out-of-range branch target
// raises the fault flag.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int PC_BITS        = FETCH_PC_BITS,
    parameter int INST_MEM_DEPTH = FETCH_INST_MEM_DEPTH
) (
    input  logic [PC_BITS-1:0] cur_pc_i,
    input  logic               branch_en_i,
    input  logic [PC_BITS-1:0] branch_target_i,
    output logic [PC_BITS-1:0] next_pc_o,
    output logic               fault_o
);

    // One extra bit so the depth compare never truncates the constant.
    localparam logic [PC_BITS:0] DEPTH_EXT = (PC_BITS + 1)'(INST_MEM_DEPTH);

    logic [PC_BITS-1:0] incr_pc;

    // Increment wraps modulo 2^PC_BITS before the depth check.
    assign incr_pc = cur_pc_i + 1'b1;

    // Select branch or sequential PC and fold out-of-range values to zero.
    always_comb begin
        next_pc_o = incr_pc;
        fault_o   = 1'b0;
        if (branch_en_i) begin
            if ({1'b0, branch_target_i} >= DEPTH_EXT) begin
                fault_o   = 1'b1;
                next_pc_o = '0;
            end else begin
                next_pc_o = branch_target_i;
            end
        end else if ({1'b0, incr_pc} >= DEPTH_EXT) begin
            next_pc_o = '0;
        end
    end

endmodule : fetch_next_pc

// File: rtl/device_fetch.sv
// Instruction-fetch sequencer. Drives the PC register input, waits out the
// register latency, reads instruction memory at the presented PC and hands
// the word to the decoder over valid/ready.
// Optional feature macro: FETCH_PERF_CNT_EN adds saturating fetch and branch
// handshake counters (o_fetch_count, o_branch_count).
module device_fetch
    import fetch_pkg::*;
#(
    parameter int PC_BITS        = FETCH_PC_BITS,
    parameter int INST_BITS      = FETCH_INST_BITS,
    parameter int INST_MEM_DEPTH = FETCH_INST_MEM_DEPTH,
    parameter int PC_LATENCY     = FETCH_PC_LATENCY
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic [PC_BITS-1:0]   i_pc,
    output logic [PC_BITS-1:0]   o_next_pc,
    output logic                 o_imem_req,
    output logic [PC_BITS-1:0]   o_imem_addr,
    input  logic                 i_imem_ack,
    input  logic [INST_BITS-1:0] i_imem_data,
    output logic [INST_BITS-1:0] o_inst,
    output logic [PC_BITS-1:0]   o_inst_pc,
    output logic                 o_inst_valid,
    input  logic                 i_inst_ready,
    input  logic                 i_branch_en,
    input  logic [PC_BITS-1:0]   i_branch_target,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]          o_fetch_count,
    output logic [15:0]          o_branch_count,
`endif
    output logic                 o_fault
);

    localparam int CNT_W = (PC_LATENCY < 2) ? 1 : $clog2(PC_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(PC_LATENCY);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PC_BITS-1:0]     next_pc_q, next_pc_d;
    logic                   req_q, req_d;
    logic [PC_BITS-1:0]     addr_q, addr_d;
    logic [INST_BITS-1:0]   inst_q, inst_d;
    logic [PC_BITS-1:0]     inst_pc_q, inst_pc_d;
    logic                   valid_q, valid_d;
    logic                   fault_q, fault_d;

    logic [PC_BITS-1:0]     calc_pc;
    logic                   calc_fault;
    logic                   handshake;

    assign handshake = (state_q == S_DELIVER) && i_inst_ready;

    fetch_next_pc #(
        .PC_BITS        (PC_BITS),
        .INST_MEM_DEPTH (INST_MEM_DEPTH)
    ) u_next_pc (
        .cur_pc_i        (inst_pc_q),
        .branch_en_i     (i_branch_en),
        .branch_target_i (i_branch_target),
        .next_pc_o       (calc_pc),
        .fault_o         (calc_fault)
    );

    // Sequencer next-state and registered-output update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        next_pc_d = next_pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        fault_d   = 1'b0;
        case (state_q)
            S_SETTLE: begin
                // i_pc is not trusted until the counter runs out.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                addr_d  = i_pc;
                req_d   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_imem_ack) begin
                    inst_d    = i_imem_data;
                    inst_pc_d = addr_q;
                    req_d     = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = S_DELIVER;
                end
            end
            S_DELIVER: begin
                if (handshake) begin
                    valid_d   = 1'b0;
                    next_pc_d = calc_pc;
                    fault_d   = calc_fault;
                    cnt_d     = CNT_RELOAD;
                    state_d   = S_SETTLE;
                end
            end
            default: begin
                state_d = S_SETTLE;
                cnt_d   = CNT_RELOAD;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight memory request.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= S_SETTLE;
            cnt_q     <= CNT_RELOAD;
            next_pc_q <= PC_BITS'(RESET_PC);
            req_q     <= 1'b0;
            addr_q    <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            next_pc_q <= next_pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
        end
    end

    assign o_next_pc    = next_pc_q;
    assign o_imem_req   = req_q;
    assign o_imem_addr  = addr_q;
    assign o_inst       = inst_q;
    assign o_inst_pc    = inst_pc_q;
    assign o_inst_valid = valid_q;
    assign o_fault      = fault_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [15:0] branch_cnt_q, branch_cnt_d;

    // Saturating handshake counters.
    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        branch_cnt_d = branch_cnt_q;
        if (handshake) begin
            if (fetch_cnt_q != 16'hFFFF) begin
                fetch_cnt_d = fetch_cnt_q + 16'd1;
            end
            if (i_branch_en && (branch_cnt_q != 16'hFFFF)) begin
                branch_cnt_d = branch_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            fetch_cnt_q  <= '0;
            branch_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign o_fetch_count  = fetch_cnt_q;
    assign o_branch_count = branch_cnt_q;
`endif

endmodule : device_fetch
